// File: rtl/cnn_frame_sequencer_pkg.sv
// cnn_frame_sequencer_pkg: shared state, error codes and widths for the frame sequencer
package cnn_frame_sequencer_pkg;
    localparam int PIX_W = 8;
    localparam int RES_W = 48;
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_START, S_STREAM, S_DRAIN, S_FC_RUN, S_DONE, S_ERROR
    } seq_state_t;
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_COUNT = 2'b10;
endpackage

// File: rtl/cnn_frame_sequencer_if.sv
// cnn_frame_sequencer_if: control, pixel stream, feature and FC result signals of the frame sequencer
interface cnn_frame_sequencer_if;
    import cnn_frame_sequencer_pkg::*;
    logic i_frame_req, i_abort, i_clr_err, i_feat_valid, i_buf_full, i_fc_valid, s_valid;
    logic s_ready, o_start, o_pixel_valid, o_buf_clear, o_fc_start, o_busy, o_result_valid;
    logic [PIX_W-1:0] s_data, o_pixel;
    logic [RES_W-1:0] i_fc_data, o_result;
    logic [15:0] o_frame_cnt;
    logic [1:0] o_err;
    modport master (
        output i_frame_req, i_abort, i_clr_err, i_feat_valid, i_buf_full, i_fc_valid, s_valid, s_data, i_fc_data,
        input s_ready, o_start, o_pixel_valid, o_pixel, o_buf_clear, o_fc_start, o_busy, o_result_valid,
        input o_result, o_frame_cnt, o_err
    );
    modport slave (
        input i_frame_req, i_abort, i_clr_err, i_feat_valid, i_buf_full, i_fc_valid, s_valid, s_data, i_fc_data,
        output s_ready, o_start, o_pixel_valid, o_pixel, o_buf_clear, o_fc_start, o_busy, o_result_valid,
        output o_result, o_frame_cnt, o_err
    );
endinterface

// File: rtl/cnn_frame_sequencer_watchdog.sv
// cnn_watchdog: counts unkicked cycles while enabled and flags expiry after TIMEOUT of them
module cnn_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic kick,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else cnt_q <= (!en || kick) ? '0 : cnt_q + 1'b1;
    end
    assign expired = en && cnt_q == CW'(TIMEOUT - 1);
endmodule

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: per-frame controller for extractor, flatten buffer and FC layer
module cnn_frame_sequencer
    import cnn_frame_sequencer_pkg::*;
#(
    parameter int NUM_PIX = 1024,
    parameter int NUM_FEAT = 225,
    parameter int TIMEOUT = 4096
) (
    input logic clk,
    input logic rst,
    cnn_frame_sequencer_if.slave bus
);
    localparam int PCW = $clog2(NUM_PIX + 1);
    localparam int FCW = $clog2(NUM_FEAT + 2);
    seq_state_t state_q, state_d;
    logic [PCW-1:0] pix_cnt_q, pix_cnt_d;
    logic [FCW-1:0] feat_cnt_q, feat_cnt_d;
    logic [PIX_W-1:0] pixel_q, pixel_d;
    logic [RES_W-1:0] result_q, result_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [1:0] err_q, err_d;
    logic pix_valid_q, pix_valid_d, start_q, start_d, clear_q, clear_d;
    logic fc_start_q, fc_start_d, res_valid_q, res_valid_d;
    logic beat, last_beat, abort, feat_in, feat_ok, expired, stall;

    assign bus.s_ready = state_q == S_STREAM;
    assign beat = bus.s_valid && bus.s_ready;
    assign last_beat = beat && pix_cnt_q == PCW'(NUM_PIX - 1);
    assign abort = bus.i_abort && state_q != S_IDLE;
    assign feat_in = bus.i_feat_valid && (state_q == S_STREAM || state_q == S_DRAIN);
    assign feat_ok = feat_cnt_q == FCW'(NUM_FEAT);
    // progress in the same cycle as expiry still counts as activity
    assign stall = expired && !(beat || bus.i_feat_valid);

    cnn_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk,
        .rst,
        .en(state_q inside {S_STREAM, S_DRAIN, S_FC_RUN}),
        .kick(state_d != state_q || beat || bus.i_feat_valid),
        .expired
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) state_d = S_IDLE;
        else case (state_q)
            S_IDLE:   state_d = bus.i_frame_req ? S_CLEAR : S_IDLE;
            S_CLEAR:  state_d = S_START;
            S_START:  state_d = S_STREAM;
            S_STREAM: state_d = last_beat ? S_DRAIN : stall ? S_ERROR : S_STREAM;
            S_DRAIN:  state_d = bus.i_buf_full ? (feat_ok ? S_FC_RUN : S_ERROR) : stall ? S_ERROR : S_DRAIN;
            S_FC_RUN: state_d = bus.i_fc_valid ? S_DONE : stall ? S_ERROR : S_FC_RUN;
            S_DONE:   state_d = S_IDLE;
            S_ERROR:  state_d = bus.i_clr_err ? S_IDLE : S_ERROR;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pix_cnt_d = state_q == S_CLEAR ? '0 : pix_cnt_q + PCW'(beat);
        feat_cnt_d = state_q == S_CLEAR ? '0 : feat_cnt_q + FCW'(feat_in && feat_cnt_q != FCW'(NUM_FEAT + 1));
        pix_valid_d = beat;
        pixel_d = beat ? bus.s_data : pixel_q;
        clear_d = state_d == S_CLEAR || abort;
        start_d = state_d == S_START;
        fc_start_d = state_q == S_DRAIN && state_d == S_FC_RUN;
        res_valid_d = state_d == S_DONE;
        result_d = (state_q == S_FC_RUN && state_d == S_DONE) ? bus.i_fc_data : result_q;
        frame_cnt_d = frame_cnt_q + 16'(state_q == S_DONE && !abort);
        err_d = (state_d == S_ERROR && state_q != S_ERROR)
              ? ((state_q == S_DRAIN && bus.i_buf_full) ? ERR_COUNT : ERR_TIMEOUT)
              : bus.i_clr_err ? ERR_NONE : err_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_cnt_q <= '0;
            feat_cnt_q <= '0;
            pixel_q <= '0;
            result_q <= '0;
            frame_cnt_q <= '0;
            err_q <= ERR_NONE;
            pix_valid_q <= 1'b0;
            start_q <= 1'b0;
            clear_q <= 1'b0;
            fc_start_q <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            pix_cnt_q <= pix_cnt_d;
            feat_cnt_q <= feat_cnt_d;
            pixel_q <= pixel_d;
            result_q <= result_d;
            frame_cnt_q <= frame_cnt_d;
            err_q <= err_d;
            pix_valid_q <= pix_valid_d;
            start_q <= start_d;
            clear_q <= clear_d;
            fc_start_q <= fc_start_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.o_busy = state_q != S_IDLE;
    assign bus.o_start = start_q;
    assign bus.o_buf_clear = clear_q;
    assign bus.o_fc_start = fc_start_q;
    assign bus.o_pixel_valid = pix_valid_q;
    assign bus.o_pixel = pixel_q;
    assign bus.o_result_valid = res_valid_q;
    assign bus.o_result = result_q;
    assign bus.o_frame_cnt = frame_cnt_q;
    assign bus.o_err = err_q;
endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// tb_cnn_frame_sequencer: directed frames with randomized pixels and stalls checked against expected behaviour
module tb_cnn_frame_sequencer;
    localparam int NUM_PIX = 1024;
    localparam int NUM_FEAT = 225;
    localparam int TIMEOUT = 4096;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    int edges = 0;
    int last_beat_edge = 0;
    int n_clear = 0, n_start = 0, n_fc = 0, n_rv = 0;
    logic [7:0] got_q[$];
    logic [7:0] pix [NUM_PIX];
    logic [47:0] r2;

    cnn_frame_sequencer_if bus();
    cnn_frame_sequencer #(.NUM_PIX(NUM_PIX), .NUM_FEAT(NUM_FEAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges++;

    // observe pulses and the pixel stream mid-cycle
    always @(negedge clk) begin
        n_clear += int'(bus.o_buf_clear);
        n_start += int'(bus.o_start);
        n_fc += int'(bus.o_fc_start);
        n_rv += int'(bus.o_result_valid);
        if (bus.o_pixel_valid) got_q.push_back(bus.o_pixel);
        if (bus.s_valid && bus.s_ready) last_beat_edge = edges + 1;
    end

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        foreach (pix[i]) pix[i] = 8'($urandom);
        bus.i_frame_req = 1'b1;
        tick(1);
        bus.i_frame_req = 1'b0;
    endtask

    task automatic send(int n, int pct);
        int k = 0;
        for (int c = 0; c < 20000 && k < n; c++) begin
            bus.s_valid = $urandom_range(99) < pct;
            bus.s_data = pix[k];
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) k++;
            tick(1);
        end
        bus.s_valid = 1'b0;
        chk("beats_accepted", 64'(k), 64'(n));
    endtask

    task automatic reach_fc(int pct, int nfeat);
        start_frame();
        send(NUM_PIX, pct);
        chk("s_ready_after_last", bus.s_ready, 0);
        bus.i_feat_valid = 1'b1;
        tick(nfeat);
        bus.i_feat_valid = 1'b0;
        bus.i_buf_full = 1'b1;
        tick(3);
        bus.i_buf_full = 1'b0;
    endtask

    task automatic do_frame(int pct, logic [47:0] d, logic [15:0] cnt_exp);
        int b_clr = n_clear, b_st = n_start, b_fc = n_fc, b_rv = n_rv, base = got_q.size();
        reach_fc(pct, NUM_FEAT);
        bus.i_fc_valid = 1'b1;
        bus.i_fc_data = d;
        tick(1);
        bus.i_fc_valid = 1'b0;
        chk("result_valid", bus.o_result_valid, 1);
        chk("result", bus.o_result, d);
        tick(2);
        chk("frame_cnt", bus.o_frame_cnt, cnt_exp);
        chk("busy_after_done", bus.o_busy, 0);
        chk("result_hold", bus.o_result, d);
        chk("n_buf_clear", 64'(n_clear - b_clr), 1);
        chk("n_start", 64'(n_start - b_st), 1);
        chk("n_fc_start", 64'(n_fc - b_fc), 1);
        chk("n_result_valid", 64'(n_rv - b_rv), 1);
        chk("n_pixels", 64'(got_q.size() - base), NUM_PIX);
        for (int i = 0; i < NUM_PIX; i++) chk("pixel_order", got_q[base + i], pix[i]);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_start", bus.o_start, 0);
        chk("rst_buf_clear", bus.o_buf_clear, 0);
        chk("rst_fc_start", bus.o_fc_start, 0);
        chk("rst_pixel_valid", bus.o_pixel_valid, 0);
        chk("rst_pixel", bus.o_pixel, 0);
        chk("rst_result_valid", bus.o_result_valid, 0);
        chk("rst_result", bus.o_result, 0);
        chk("rst_frame_cnt", bus.o_frame_cnt, 0);
        chk("rst_err", bus.o_err, 0);
    endtask

    initial begin
        int b_clr, b_fc, b_rv;
        bus.i_frame_req = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_clr_err = 1'b0;
        bus.i_feat_valid = 1'b0;
        bus.i_buf_full = 1'b0;
        bus.i_fc_valid = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.i_fc_data = '0;
        tick(3);
        chk_reset_outputs();
        rst = 1'b1;
        tick(2);

        do_frame(100, 48'h0000_0000_1234, 16'd1);
        r2 = 48'({$urandom, $urandom});
        do_frame(50, r2, 16'd2);

        b_fc = n_fc;
        reach_fc(100, NUM_FEAT - 1);
        chk("count_err", bus.o_err, 2'b10);
        chk("count_no_fc_start", 64'(n_fc - b_fc), 0);
        chk("count_busy", bus.o_busy, 1);
        bus.i_clr_err = 1'b1;
        tick(1);
        bus.i_clr_err = 1'b0;
        chk("count_clr_err", bus.o_err, 0);
        chk("count_clr_busy", bus.o_busy, 0);

        start_frame();
        send(500, 100);
        for (int c = 0; c < TIMEOUT + 20 && bus.o_err == 2'b00; c++) tick(1);
        chk("timeout_err", bus.o_err, 2'b01);
        chk("timeout_latency", 64'(edges - last_beat_edge), TIMEOUT);
        bus.i_frame_req = 1'b1;
        tick(5);
        bus.i_frame_req = 1'b0;
        chk("timeout_busy", bus.o_busy, 1);
        chk("timeout_err_sticky", bus.o_err, 2'b01);
        bus.i_clr_err = 1'b1;
        tick(1);
        bus.i_clr_err = 1'b0;
        chk("timeout_clr_err", bus.o_err, 0);
        chk("timeout_clr_busy", bus.o_busy, 0);

        reach_fc(100, NUM_FEAT);
        b_clr = n_clear;
        b_rv = n_rv;
        bus.i_abort = 1'b1;
        tick(1);
        bus.i_abort = 1'b0;
        chk("abort_busy", bus.o_busy, 0);
        chk("abort_buf_clear", bus.o_buf_clear, 1);
        bus.i_fc_valid = 1'b1;
        bus.i_fc_data = 48'hDEAD_BEEF_0001;
        tick(1);
        bus.i_fc_valid = 1'b0;
        tick(3);
        chk("abort_n_clear", 64'(n_clear - b_clr), 1);
        chk("abort_n_rv", 64'(n_rv - b_rv), 0);
        chk("abort_frame_cnt", bus.o_frame_cnt, 2);
        chk("abort_result", bus.o_result, r2);
        chk("abort_err", bus.o_err, 0);
        chk("abort_idle", bus.o_busy, 0);

        start_frame();
        send(300, 100);
        chk("pre_reset_busy", bus.o_busy, 1);
        rst = 1'b0;
        #1;
        chk_reset_outputs();
        tick(2);
        rst = 1'b1;
        tick(2);
        do_frame(100, 48'h8000_0000_0007, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
